// File: rtl/decode_if.sv
// Decode-stage port bundle: fetch/control drives the instruction fields and writeback,
// the decode stage answers with in_ready and the registered ID/EX contents.
interface decode_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    rs_sel;
  logic [AW-1:0]    rt_sel;
  logic             rs_used;
  logic             rt_used;
  logic [AW-1:0]    rd_sel;
  logic             rd_write;
  logic             rd_is_load;
  logic             wb_en;
  logic [AW-1:0]    wb_sel;
  logic [WIDTH-1:0] wb_data;
  logic             ex_ready;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [AW-1:0]    out_rd;
  logic             out_rd_write;
  logic             out_rd_is_load;
  logic             err;

  modport master (
    output in_valid, rs_sel, rt_sel, rs_used, rt_used, rd_sel, rd_write, rd_is_load,
           wb_en, wb_sel, wb_data, ex_ready, flush,
    input  in_ready, out_valid, out_a, out_b, out_rd, out_rd_write, out_rd_is_load, err
  );

  modport slave (
    input  in_valid, rs_sel, rt_sel, rs_used, rt_used, rd_sel, rd_write, rd_is_load,
           wb_en, wb_sel, wb_data, ex_ready, flush,
    output in_ready, out_valid, out_a, out_b, out_rd, out_rd_write, out_rd_is_load, err
  );
endinterface

// File: rtl/decode_pipe.sv
// WISC pipelined decode stage: register file with writeback bypass, pending-load
// scoreboard for load-use/WAW stalls, and a valid/ready ID/EX register with flush.
module decode_pipe #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input logic      clk,
  input logic      rst,
  decode_if.slave  bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [WIDTH-1:0] rf_q [NREGS];
  logic [WIDTH-1:0] rf_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [AW-1:0]    out_rd_q, out_rd_d;
  logic             out_rd_write_q, out_rd_write_d;
  logic             out_rd_is_load_q, out_rd_is_load_d;
  logic             err_q, err_d;

  // Sources: 0 = rs, 1 = rt, 2 = rd (checked for WAW against pending loads).
  logic [2:0][AW-1:0] src_sel;
  logic [2:0]         src_used;
  logic [2:0]         src_busy, src_bad, src_pend, wb_hit;
  logic [WIDTH-1:0]   opnd [2];
  logic               wb_bad;
  logic               ld_in_idex, ld_leave;
  logic               stall, in_ready, accept;

  assign src_sel  = {bus.rd_sel, bus.rt_sel, bus.rs_sel};
  assign src_used = {bus.rd_write, bus.rt_used, bus.rs_used};

  assign ld_in_idex = out_valid_q & out_rd_write_q & out_rd_is_load_q;
  assign ld_leave   = ld_in_idex & bus.ex_ready;

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    src_busy = '0;
    src_bad  = '1;
    src_pend = '0;
    wb_hit   = '0;
    wb_bad   = 1'b1;
    opnd[0]  = '0;
    opnd[1]  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.wb_sel == AW'(i)) wb_bad = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      wb_hit[k] = bus.wb_en & (bus.wb_sel == src_sel[k]);
      for (int i = 0; i < NREGS; i++) begin
        if (src_sel[k] == AW'(i)) begin
          src_bad[k]  = 1'b0;
          src_busy[k] = busy_q[i];
        end
      end
      // A same-cycle writeback retires the scoreboard entry but not a load still in ID/EX.
      src_pend[k] = (src_busy[k] & ~wb_hit[k]) | (ld_in_idex & (out_rd_q == src_sel[k]));
    end
    // Selects beyond NREGS match no entry and read as zero.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NREGS; i++) begin
        if (src_sel[k] == AW'(i)) opnd[k] = wb_hit[k] ? bus.wb_data : rf_q[i];
      end
    end
  end

  assign stall    = |(src_used & src_pend);
  assign in_ready = ~bus.flush & ~stall & (~out_valid_q | bus.ex_ready);
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.wb_en && bus.wb_sel == AW'(i)) begin
        rf_d[i]   = bus.wb_data;
        busy_d[i] = 1'b0;
      end
    end
    // Applied after the clear so a load leaving ID/EX wins over a same-register writeback.
    for (int i = 0; i < NREGS; i++) begin
      if (ld_leave && out_rd_q == AW'(i)) busy_d[i] = 1'b1;
    end

    out_valid_d      = out_valid_q;
    out_a_d          = out_a_q;
    out_b_d          = out_b_q;
    out_rd_d         = out_rd_q;
    out_rd_write_d   = out_rd_write_q;
    out_rd_is_load_d = out_rd_is_load_q;
    if (accept) begin
      out_valid_d      = 1'b1;
      out_a_d          = opnd[0];
      out_b_d          = opnd[1];
      out_rd_d         = bus.rd_sel;
      out_rd_write_d   = bus.rd_write;
      out_rd_is_load_d = bus.rd_is_load;
    end else if (bus.ex_ready || bus.flush) begin
      out_valid_d = 1'b0;
    end

    err_d = err_q | (bus.wb_en & wb_bad) | (accept & |(src_used & src_bad));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is reset because architectural registers must read zero after reset.
      rf_q             <= '{default: '0};
      busy_q           <= '0;
      out_valid_q      <= 1'b0;
      out_a_q          <= '0;
      out_b_q          <= '0;
      out_rd_q         <= '0;
      out_rd_write_q   <= 1'b0;
      out_rd_is_load_q <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      rf_q             <= rf_d;
      busy_q           <= busy_d;
      out_valid_q      <= out_valid_d;
      out_a_q          <= out_a_d;
      out_b_q          <= out_b_d;
      out_rd_q         <= out_rd_d;
      out_rd_write_q   <= out_rd_write_d;
      out_rd_is_load_q <= out_rd_is_load_d;
      err_q            <= err_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_a          = out_a_q;
  assign bus.out_b          = out_b_q;
  assign bus.out_rd         = out_rd_q;
  assign bus.out_rd_write   = out_rd_write_q;
  assign bus.out_rd_is_load = out_rd_is_load_q;
  assign bus.err            = err_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Directed and randomized bench for decode_pipe (NREGS=6 so illegal selects exist),
// checked every cycle against a register/scoreboard reference model.
module tb_decode_pipe;
  localparam int W = 16;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  decode_if #(.WIDTH(W), .NREGS(N)) bus ();
  decode_pipe #(.WIDTH(W), .NREGS(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference model state
  logic [W-1:0] m_regs [N];
  bit   [N-1:0] m_busy;
  bit           m_ov, m_w, m_ld, m_err;
  logic [W-1:0] m_a, m_b;
  int           m_rd;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_busy = '0;
    m_ov = 0; m_w = 0; m_ld = 0; m_err = 0;
    m_a = '0; m_b = '0; m_rd = 0;
  endtask

  function automatic bit m_pending(int s);
    bit scoreboard, in_flight;
    scoreboard = (s < N) && m_busy[s] && !(bus.wb_en && int'(bus.wb_sel) == s);
    in_flight  = m_ov && m_w && m_ld && (m_rd == s);
    return scoreboard || in_flight;
  endfunction

  function automatic logic [W-1:0] m_read(int s);
    if (s >= N) return '0;
    if (bus.wb_en && int'(bus.wb_sel) == s) return bus.wb_data;
    return m_regs[s];
  endfunction

  function automatic bit m_ready();
    bit stall;
    stall = (bus.rs_used  && m_pending(int'(bus.rs_sel))) ||
            (bus.rt_used  && m_pending(int'(bus.rt_sel))) ||
            (bus.rd_write && m_pending(int'(bus.rd_sel)));
    return !bus.flush && !stall && (!m_ov || bus.ex_ready);
  endfunction

  task automatic model_edge(bit rdy);
    bit acc, bad, leave;
    int leave_rd, ws;
    logic [W-1:0] a, b;
    acc = bus.in_valid && rdy;
    bad = (bus.rs_used && int'(bus.rs_sel) >= N) || (bus.rt_used && int'(bus.rt_sel) >= N) ||
          (bus.rd_write && int'(bus.rd_sel) >= N);
    a = m_read(int'(bus.rs_sel));
    b = m_read(int'(bus.rt_sel));
    leave = m_ov && bus.ex_ready && m_w && m_ld;
    leave_rd = m_rd;
    ws = int'(bus.wb_sel);
    if (bus.wb_en && ws >= N) m_err = 1;
    if (acc && bad) m_err = 1;
    if (bus.wb_en && ws < N) begin
      m_regs[ws] = bus.wb_data;
      m_busy[ws] = 0;
    end
    if (leave && leave_rd < N) m_busy[leave_rd] = 1;
    if (acc) begin
      m_ov = 1; m_a = a; m_b = b;
      m_rd = int'(bus.rd_sel); m_w = bus.rd_write; m_ld = bus.rd_is_load;
    end else if (bus.ex_ready || bus.flush) begin
      m_ov = 0;
    end
  endtask

  task automatic model_check();
    check("out_valid", bus.out_valid, m_ov);
    if (m_ov) begin
      check("out_a", bus.out_a, m_a);
      check("out_b", bus.out_b, m_b);
      check("out_rd", bus.out_rd, m_rd);
      check("out_rd_write", bus.out_rd_write, m_w);
      check("out_rd_is_load", bus.out_rd_is_load, m_ld);
    end
    check("err", bus.err, m_err);
  endtask

  // One clock: inputs already driven; check in_ready, clock, update model, check outputs.
  task automatic step();
    bit rdy;
    #1;
    rdy = m_ready();
    check("in_ready", bus.in_ready, rdy);
    @(posedge clk);
    model_edge(rdy);
    #1;
    model_check();
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.rs_sel = '0; bus.rt_sel = '0; bus.rs_used = 0; bus.rt_used = 0;
    bus.rd_sel = '0; bus.rd_write = 0; bus.rd_is_load = 0;
    bus.wb_en = 0; bus.wb_sel = '0; bus.wb_data = '0;
    bus.ex_ready = 1; bus.flush = 0;
  endtask

  task automatic wb(int sel, logic [W-1:0] data);
    bus.wb_en = 1; bus.wb_sel = 3'(sel); bus.wb_data = data;
  endtask

  task automatic issue(int rs, bit rs_u, int rt, bit rt_u, int rd, bit rd_w, bit rd_l);
    bus.in_valid = 1;
    bus.rs_sel = 3'(rs); bus.rs_used = rs_u;
    bus.rt_sel = 3'(rt); bus.rt_used = rt_u;
    bus.rd_sel = 3'(rd); bus.rd_write = rd_w; bus.rd_is_load = rd_l;
  endtask

  task automatic pulse_reset(string tag);
    #2 rst = 1;
    #1;
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_a"}, bus.out_a, 0);
    model_reset();
    @(negedge clk) rst = 0;
  endtask

  task automatic randomize_inputs();
    bus.in_valid   = ($urandom_range(0, 3) != 0);
    bus.rs_sel     = 3'($urandom_range(0, N - 1));
    bus.rt_sel     = 3'($urandom_range(0, N - 1));
    bus.rd_sel     = 3'($urandom_range(0, N - 1));
    bus.rs_used    = 1'($urandom_range(0, 1));
    bus.rt_used    = 1'($urandom_range(0, 1));
    bus.rd_write   = ($urandom_range(0, 3) != 0);
    bus.rd_is_load = ($urandom_range(0, 2) == 0);
    bus.wb_en      = ($urandom_range(0, 2) == 0);
    bus.wb_sel     = 3'($urandom_range(0, N - 1));
    bus.wb_data    = 16'($urandom);
    bus.ex_ready   = ($urandom_range(0, 3) != 0);
    bus.flush      = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_a", bus.out_a, 0);
    check("rst_b", bus.out_b, 0);
    check("rst_rd", bus.out_rd, 0);
    check("rst_flags", {bus.out_rd_write, bus.out_rd_is_load}, 0);
    check("rst_err", bus.err, 0);
    @(negedge clk) rst = 0;

    // Writeback then read through the array
    idle(); wb(3, 16'h1234); step();
    idle(); wb(1, 16'h5A5A); step();
    idle(); issue(3, 1, 0, 0, 0, 0, 0); step();
    check("rd_array_valid", bus.out_valid, 1);
    check("rd_array_a", bus.out_a, 16'h1234);

    // Same-cycle bypass
    idle(); wb(5, 16'hBEEF); issue(0, 0, 5, 1, 0, 0, 0); step();
    check("bypass_b", bus.out_b, 16'hBEEF);

    // Load-use stall until writeback
    idle(); issue(0, 0, 0, 0, 2, 1, 1); step();
    idle(); issue(2, 1, 0, 0, 0, 0, 0); #1;
    check("ld_stall_idex", bus.in_ready, 0);
    step();
    #1 check("ld_stall_busy", bus.in_ready, 0);
    step();
    wb(2, 16'h00AA); #1;
    check("ld_wb_ready", bus.in_ready, 1);
    step();
    check("ld_use_a", bus.out_a, 16'h00AA);

    // Back-pressure
    idle(); issue(1, 1, 0, 0, 0, 0, 0); step();
    idle(); bus.ex_ready = 0; issue(3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", bus.in_ready, 0);
      step();
      check("bp_hold_a", bus.out_a, 16'h5A5A);
      check("bp_hold_valid", bus.out_valid, 1);
    end
    bus.ex_ready = 1; step();
    check("bp_next_a", bus.out_a, 16'h1234);
    idle(); step();
    check("bp_drain_valid", bus.out_valid, 0);

    // Flush a load in ID/EX
    idle(); issue(0, 0, 0, 0, 4, 1, 1); step();
    idle(); bus.flush = 1; bus.ex_ready = 0; step();
    check("flush_valid", bus.out_valid, 0);
    idle(); issue(4, 1, 0, 0, 0, 0, 0); #1;
    check("flush_no_stall", bus.in_ready, 1);
    step();
    check("flush_next_valid", bus.out_valid, 1);
    idle(); step();
    idle(); issue(4, 1, 4, 1, 4, 1, 0); #1;
    check("flush_busy_clear", bus.in_ready, 1);
    step();

    // Illegal writeback select
    idle(); wb(7, 16'hFFFF); step();
    check("err_wb", bus.err, 1);
    idle(); step();
    check("err_sticky", bus.err, 1);
    pulse_reset("err_rst");

    // Illegal read select on accept
    idle(); issue(6, 1, 0, 0, 0, 0, 0); step();
    check("err_rd", bus.err, 1);
    check("err_rd_a", bus.out_a, 0);
    pulse_reset("err_rst2");

    // Randomized traffic with a mid-run reset while a load is pending
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      step();
      if (n == 200) begin
        idle(); issue(0, 0, 0, 0, 1, 1, 1); step();
        idle(); step();
        pulse_reset("mid_rst");
        idle(); issue(1, 1, 0, 0, 1, 1, 0); #1;
        check("mid_rst_busy", bus.in_ready, 1);
        step();
      end
    end

    idle(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised decode stage for the WISC pipeline: an N-entry, W-bit register file with write-to-read bypass, a pending-load scoreboard, and a registered ID/EX output stage with a valid/ready handshake and flush. It sits between fetch/control (which supplies register selects and write/load flags) and execute. It is the pipelined successor to the single-cycle decode: it adds back-pressure, load-use stalling and configurable width/depth.

## Interface
- WIDTH, 16, data width of registers and operands
- NREGS, 8, number of architectural registers (AW = $clog2(NREGS), derived)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  decoded instruction fields valid
- in_ready  output  1  stage accepts instruction this cycle
- rs_sel, rt_sel  input  AW  source register selects
- rs_used, rt_used  input  1  source actually read (gates hazard check)
- rd_sel  input  AW  destination register
- rd_write  input  1  instruction writes rd
- rd_is_load  input  1  rd result comes from memory
- wb_en  input  1  writeback strobe
- wb_sel  input  AW  writeback register
- wb_data  input  WIDTH  writeback data
- ex_ready  input  1  execute accepts ID/EX contents
- flush  input  1  kill ID/EX contents and block acceptance
- out_valid  output  1  ID/EX holds a live instruction
- out_a, out_b  output  WIDTH  operands read from rs, rt
- out_rd  output  AW; out_rd_write, out_rd_is_load  output  1  destination info
- err  output  1  sticky illegal-select error

## Operation
- Register file: NREGS x WIDTH. Written at the clock edge when wb_en. No hard-wired zero register.
- Read: rs/rt index the array. If wb_en and wb_sel matches the select in the same cycle, the read returns wb_data (bypass).
- busy[NREGS] scoreboard:
  - Set for out_rd when out_valid & ex_ready & out_rd_write & out_rd_is_load (load leaves ID/EX).
  - Cleared when wb_en for wb_sel.
  - If set and clear hit the same register in the same cycle, set wins.
- Hazard (stall):
  - A source is pending if busy[src], or if out_valid & out_rd_write & out_rd_is_load & out_rd == src.
  - A wb_en to that register in the same cycle clears the busy[src] term only.
  - Stall if (rs_used & rs pending) | (rt_used & rt pending) | (rd_write & rd_sel pending) (WAW).
- in_ready = ~flush & ~stall & (~out_valid | ex_ready). accept = in_valid & in_ready.
- ID/EX register:
  - On accept it loads the operands and rd fields and sets out_valid.
  - Else, if ex_ready or flush, out_valid clears.
  - Else it holds; all out_* stay stable while out_valid & ~ex_ready.
- Flush:
  - out_valid goes to 0 next edge, with no accept that cycle.
  - busy is untouched, because loads already past ID/EX are older and still write back.
- err: sets and stays set until rst when either of these occurs:
  - wb_en with wb_sel >= NREGS;
  - accept with any used select >= NREGS.
  - The offending write or read is dropped (the read returns 0).
  - This can only fire when NREGS is not a power of two.

## Timing
- Reset (async): all registers 0, busy 0, out_valid 0, out_a/out_b/out_rd/flags 0, err 0. in_ready may rise in the first cycle after rst deasserts.
- Decode latency: 1 cycle from accept to out_valid with data.
- Throughput: 1 instruction per cycle with no hazard and ex_ready high.
- Writeback is visible to a same-cycle read through bypass, and to all later reads from the array.
- Load-use timing:
  - A dependent instruction stalls while the load is in ID/EX, and from its departure until its wb_en.
  - It is accepted in the wb_en cycle.
- rst mid-operation discards everything, including pending scoreboard entries.

## Test plan
- Reset, then write R3=0x1234 via wb and read rs=3 two cycles later -> out_a=0x1234 one cycle after accept; out_valid=1.
- Same cycle: wb R5=0xBEEF and accept with rt=5 -> out_b=0xBEEF (bypass).
- Issue a load to R2 (rd_is_load), then an instruction reading rs=2 -> in_ready=0 until wb_en R2=0x00AA; accepted that cycle, out_a=0x00AA.
- Hold ex_ready=0 with out_valid=1 for 3 cycles while in_valid=1 -> outputs stable, in_ready=0; release -> next instruction appears one cycle later, no loss or duplication.
- Flush while ID/EX holds a load to R4 -> out_valid=0 next cycle; busy[4] never set; an instruction reading R4 is accepted with no stall.
- NREGS=6: wb_en with wb_sel=7 -> err=1 and sticky; array unchanged; rst clears err.
